// File: rtl/jk_count_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : jk_count_sequencer_if
//  Purpose  : Handshake and JK-bank signal bundle between a controller and
//             the jk_count_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface jk_count_sequencer_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic             stop;
    logic             ack;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             fb_err;

    // Controller side: issues commands and returns the bank's Q outputs.
    modport master (
        output start, stop, ack, q_fb,
        input  j, k, count, busy, done, fb_err
    );

    // Sequencer side.
    modport slave (
        input  start, stop, ack, q_fb,
        output j, k, count, busy, done, fb_err
    );
endinterface
`default_nettype wire

// File: rtl/jk_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jk_count_sequencer
//  Purpose  : Drives J/K excitation for a bank of JK flip-flops so that the
//             bank counts 0..TERMINAL, then holds and raises done until ack.
//             Optional macro JK_FB_CHECK_EN enables a sticky comparison of
//             the bank's Q feedback against the internal count mirror.
//  Revision : 1.0  initial release
// ============================================================================
module jk_count_sequencer #(
    parameter int WIDTH        = 2,
    parameter int TERMINAL     = 3,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    jk_count_sequencer_if.slave  bus
);

    // Terminal value must be reachable without the count wrapping.
    if ((TERMINAL < 1) || (TERMINAL > ((2 ** WIDTH) - 1))) begin : g_bad_terminal
        $error("jk_count_sequencer: TERMINAL must lie in 1 .. 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] c_terminal = WIDTH'(TERMINAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_term;
    logic             w_fb_mismatch;
    logic             w_accept_start;

    assign w_next         = r_count + WIDTH'(1);
    assign w_at_term      = (r_count == c_terminal);
    assign w_accept_start = (r_state == S_IDLE) && bus.start && !bus.stop;

`ifdef JK_FB_CHECK_EN
    logic r_fb_err;

    // Bank and mirror agree one cycle after every edge, so any difference
    // seen while counting or holding is a real bank fault.
    assign w_fb_mismatch = ((r_state == S_COUNT) || (r_state == S_DONE)) &&
                           (bus.q_fb != r_count);

    // Sticky fault flag, cleared only by reset or a freshly accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb_err <= 1'b0;
        end else if (w_accept_start) begin
            r_fb_err <= 1'b0;
        end else if (w_fb_mismatch) begin
            r_fb_err <= 1'b1;
        end
    end

    assign bus.fb_err = r_fb_err;
`else
    logic w_unused_q_fb;

    assign w_fb_mismatch = 1'b0;
    assign w_unused_q_fb = ^bus.q_fb;
    assign bus.fb_err    = 1'b0;
`endif

    // Sequencing state and the count mirror of the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_start) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_count <= '0;
                    r_state <= bus.stop ? S_IDLE : S_COUNT;
                end
                S_COUNT: begin
                    if (w_fb_mismatch) begin
                        r_state <= S_IDLE;
                    end else if (w_at_term) begin
                        r_state <= bus.stop ? S_IDLE : S_DONE;
                    end else begin
                        // The bank takes this cycle's excitation even on stop,
                        // so the mirror advances with it.
                        r_count <= w_next;
                        r_state <= bus.stop ? S_IDLE : S_COUNT;
                    end
                end
                S_DONE: begin
                    if (w_fb_mismatch) begin
                        r_state <= S_IDLE;
                    end else if (AUTO_RESTART) begin
                        r_state <= S_CLEAR;
                    end else if (bus.ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from registered state and count only.
    always_comb begin
        bus.j    = '0;
        bus.k    = '0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_CLEAR: begin
                bus.k    = '1;
                bus.busy = 1'b1;
            end
            S_COUNT: begin
                bus.busy = 1'b1;
                if (!w_at_term) begin
                    bus.j = ~r_count & w_next;
                    bus.k = r_count & ~w_next;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_jk_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_count_sequencer
//  Purpose  : Self-checking bench for jk_count_sequencer driving a modelled
//             two-flop JK bank (WIDTH=2, TERMINAL=3, 40ns clock).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_count_sequencer;
    localparam int WIDTH    = 2;
    localparam int TERMINAL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    jk_count_sequencer_if #(.WIDTH(WIDTH)) bus ();
    jk_count_sequencer_if #(.WIDTH(WIDTH)) bus_ar ();

    jk_count_sequencer #(.WIDTH(WIDTH), .TERMINAL(TERMINAL), .AUTO_RESTART(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    jk_count_sequencer #(.WIDTH(WIDTH), .TERMINAL(TERMINAL), .AUTO_RESTART(1'b1)) dut_ar (
        .clk (clk),
        .rst (rst),
        .bus (bus_ar.slave)
    );

    // JK bank model: two flops, own reset, optional preset and stuck-at-0 fault.
    logic [WIDTH-1:0] q_bank;
    logic             preset_req;
    logic [WIDTH-1:0] preset_val;
    logic [WIDTH-1:0] force_mask;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_bank <= '0;
        end else if (preset_req) begin
            q_bank <= preset_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({bus.j[i], bus.k[i]})
                    2'b01:   q_bank[i] <= 1'b0;
                    2'b10:   q_bank[i] <= 1'b1;
                    2'b11:   q_bank[i] <= ~q_bank[i];
                    default: q_bank[i] <= q_bank[i];
                endcase
            end
        end
    end

    assign bus.q_fb    = q_bank & ~force_mask;
    assign bus_ar.q_fb = bus_ar.count;
    assign bus_ar.stop = 1'b0;
    assign bus_ar.ack  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic       ack;
        logic [1:0] count;
        logic       busy;
        logic       done;
        logic [1:0] j;
        logic [1:0] k;
        logic [1:0] q;
    } vec_t;

    vec_t vt [21];

    // Reference model: run position -1 idle, 0 clear, 1..T+1 counting, T+2 done.
    int         m_run;
    int         m_count;
    logic [1:0] e_j, e_k, e_n, e_c;
    logic       e_busy, e_done;

    task automatic model_step(input logic s, input logic p, input logic a);
        if (m_run < 0) begin
            if (s && !p) m_run = 0;
        end else if (m_run == 0) begin
            m_count = 0;
            m_run   = p ? -1 : 1;
        end else if (m_run <= TERMINAL + 1) begin
            if (m_count == TERMINAL) begin
                m_run = p ? -1 : TERMINAL + 2;
            end else begin
                m_count = m_count + 1;
                m_run   = p ? -1 : m_run + 1;
            end
        end else begin
            if (a) m_run = -1;
        end
        e_busy = (m_run >= 0) && (m_run <= TERMINAL + 1);
        e_done = (m_run == TERMINAL + 2);
        e_j = 2'b00;
        e_k = 2'b00;
        if (m_run == 0) e_k = 2'b11;
        if (m_run >= 1 && m_run <= TERMINAL + 1 && m_count != TERMINAL) begin
            e_c = 2'(m_count);
            e_n = 2'(m_count + 1);
            for (int b = 0; b < 2; b++) begin
                e_j[b] = e_n[b] & ~e_c[b];
                e_k[b] = e_c[b] & ~e_n[b];
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.ack = 0; bus_ar.start = 0;
        force_mask = '0; preset_req = 0; preset_val = '0;

        // Reset state
        #10;
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_j", bus.j, 0);
        chk("rst_k", bus.k, 0);
        chk("rst_fb_err", bus.fb_err, 0);
        @(negedge clk);
        rst = 0;

        // Preset bank to 10 so the CLEAR phase has to clear it.
        preset_req = 1; preset_val = 2'b10;
        tick();
        preset_req = 0;
        chk("preset_q", q_bank, 2'b10);

        //         start stop ack cnt busy done j      k      q
        vt[0]  = '{1, 1, 0, 2'd0, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[1]  = '{1, 0, 0, 2'd0, 1, 0, 2'b00, 2'b11, 2'b10};
        vt[2]  = '{0, 0, 0, 2'd0, 1, 0, 2'b01, 2'b00, 2'b00};
        vt[3]  = '{1, 0, 0, 2'd1, 1, 0, 2'b10, 2'b01, 2'b01};
        vt[4]  = '{0, 0, 1, 2'd2, 1, 0, 2'b01, 2'b00, 2'b10};
        vt[5]  = '{0, 0, 0, 2'd3, 1, 0, 2'b00, 2'b00, 2'b11};
        vt[6]  = '{0, 0, 0, 2'd3, 0, 1, 2'b00, 2'b00, 2'b11};
        vt[7]  = '{1, 0, 0, 2'd3, 0, 1, 2'b00, 2'b00, 2'b11};
        vt[8]  = '{0, 0, 0, 2'd3, 0, 1, 2'b00, 2'b00, 2'b11};
        vt[9]  = '{0, 0, 1, 2'd3, 0, 0, 2'b00, 2'b00, 2'b11};
        vt[10] = '{1, 0, 0, 2'd3, 1, 0, 2'b00, 2'b11, 2'b11};
        vt[11] = '{0, 0, 0, 2'd0, 1, 0, 2'b01, 2'b00, 2'b00};
        vt[12] = '{0, 0, 0, 2'd1, 1, 0, 2'b10, 2'b01, 2'b01};
        vt[13] = '{0, 1, 0, 2'd2, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[14] = '{0, 0, 0, 2'd2, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[15] = '{0, 0, 0, 2'd2, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[16] = '{0, 0, 0, 2'd2, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[17] = '{0, 0, 0, 2'd2, 0, 0, 2'b00, 2'b00, 2'b10};
        vt[18] = '{1, 0, 0, 2'd2, 1, 0, 2'b00, 2'b11, 2'b10};
        vt[19] = '{0, 1, 0, 2'd0, 0, 0, 2'b00, 2'b00, 2'b00};
        vt[20] = '{0, 0, 1, 2'd0, 0, 0, 2'b00, 2'b00, 2'b00};

        for (int i = 0; i < 21; i++) begin
            bus.start = vt[i].start; bus.stop = vt[i].stop; bus.ack = vt[i].ack;
            tick();
            chk($sformatf("vec%0d_count", i), bus.count, vt[i].count);
            chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
            chk($sformatf("vec%0d_done", i), bus.done, vt[i].done);
            chk($sformatf("vec%0d_j", i), bus.j, vt[i].j);
            chk($sformatf("vec%0d_k", i), bus.k, vt[i].k);
            chk($sformatf("vec%0d_q", i), q_bank, vt[i].q);
        end
        bus.start = 0; bus.stop = 0; bus.ack = 0;

        // AUTO_RESTART instance: DONE falls back to CLEAR with no ack.
        bus_ar.start = 1;
        tick();
        bus_ar.start = 0;
        chk("ar_clear_k", bus_ar.k, 2'b11);
        for (int i = 0; i < TERMINAL + 2; i++) tick();
        chk("ar_done", bus_ar.done, 1);
        chk("ar_done_busy", bus_ar.busy, 0);
        tick();
        chk("ar_restart_done", bus_ar.done, 0);
        chk("ar_restart_busy", bus_ar.busy, 1);
        chk("ar_restart_k", bus_ar.k, 2'b11);
        tick();
        chk("ar_recount", bus_ar.count, 0);

        // Asynchronous reset between edges while counting.
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        tick();
        chk("pre_rst_count", bus.count, 1);
        #10;
        rst = 1;
        #2;
        chk("arst_count", bus.count, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_j", bus.j, 0);
        chk("arst_k", bus.k, 0);
        @(negedge clk);
        rst = 0;

        // Randomized run against the reference model.
        m_run = -1;
        m_count = 0;
        for (int c = 0; c < 400; c++) begin
            bus.start = ($urandom_range(0, 99) < 30);
            bus.stop  = ($urandom_range(0, 99) < 10);
            bus.ack   = ($urandom_range(0, 99) < 30);
            model_step(bus.start, bus.stop, bus.ack);
            tick();
            chk("rnd_count", bus.count, 8'(m_count));
            chk("rnd_busy", bus.busy, e_busy);
            chk("rnd_done", bus.done, e_done);
            chk("rnd_j", bus.j, e_j);
            chk("rnd_k", bus.k, e_k);
            chk("rnd_q", q_bank, 8'(m_count));
        end
        bus.start = 0; bus.stop = 0; bus.ack = 0;

        // Feedback fault: flop0 Q forced low while count=1.
        rst = 1;
        @(negedge clk);
        rst = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int c = 0; c < 10 && bus.count != 2'd1; c++) tick();
        chk("fb_reach_count1", bus.count, 1);
        force_mask = 2'b01;
        tick();
        force_mask = 2'b00;
`ifdef JK_FB_CHECK_EN
        chk("fb_err_set", bus.fb_err, 1);
        chk("fb_err_idle", bus.busy, 0);
`else
        chk("fb_err_tied", bus.fb_err, 0);
        chk("fb_ignored_count", bus.count, 2);
`endif
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("fb_err_after_start", bus.fb_err, 0);
        chk("fb_busy_after_start", bus.busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
